// File: rtl/pc_register_64.sv
// pc_register_64: sequential PC/status stage of the Y86-64 SEQ core.
// Registers new_pc into the architectural PC and owns the status code.
// Runs the IDLE/RUN/HALT/ERR run-control FSM and counts retired instructions.
// Optional feature: define PC_BREAKPOINT_EN to add the bp_en/bp_addr/bp_hit
// breakpoint ports. A breakpoint pauses the core back into IDLE.
//
// Control semantics: start is a level request sampled in IDLE only. stall
// freezes every register while in RUN; HALT and ERR are terminal until reset.
module pc_register_64 #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic [63:0]      new_pc,
    input  logic [3:0]       icode,
    input  logic             instr_valid,
    input  logic             imem_error,
    input  logic             dmem_error,
`ifdef PC_BREAKPOINT_EN
    input  logic             bp_en,
    input  logic [63:0]      bp_addr,
    output logic             bp_hit,
`endif
    output logic [63:0]      pc,
    output logic [2:0]       stat,
    output logic             running,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] ICODE_HALT = 4'h0;

    state_t           state_q, state_d;
    logic [63:0]      pc_q, pc_d;
    logic [2:0]       stat_q, stat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             running_q, running_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             bp_hit_q, bp_hit_d;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    always_comb begin
        cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // State register: reset wins over everything, in any state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            stat_q    <= STAT_AOK;
            cnt_q     <= '0;
            running_q <= 1'b0;
            bp_hit_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            stat_q    <= stat_d;
            cnt_q     <= cnt_d;
            running_q <= running_d;
            bp_hit_q  <= bp_hit_d;
        end
    end

    // Next-state logic: exceptions are checked in fetch-to-memory order.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        stat_d   = stat_q;
        cnt_d    = cnt_q;
        bp_hit_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    if (imem_error) begin
                        stat_d  = STAT_ADR;
                        state_d = ST_ERR;
                    end else if (!instr_valid) begin
                        stat_d  = STAT_INS;
                        state_d = ST_ERR;
                    end else if (dmem_error) begin
                        stat_d  = STAT_ADR;
                        state_d = ST_ERR;
                    end else if (icode == ICODE_HALT) begin
                        // The halt itself retires, but the PC stays on it.
                        stat_d  = STAT_HLT;
                        state_d = ST_HALT;
                        cnt_d   = cnt_inc;
                    end else begin
                        pc_d  = new_pc;
                        cnt_d = cnt_inc;
`ifdef PC_BREAKPOINT_EN
                        // Pause before executing the breakpoint target.
                        if (bp_en && (new_pc == bp_addr)) begin
                            state_d  = ST_IDLE;
                            bp_hit_d = 1'b1;
                        end
`endif
                    end
                end
            end
            default: begin
                // HALT and ERR are terminal; only reset leaves them.
            end
        endcase
        running_d = (state_d == ST_RUN);
    end

    // Output logic: all outputs come straight from registers.
    always_comb begin
        pc          = pc_q;
        stat        = stat_q;
        running     = running_q;
        instr_count = cnt_q;
    end

`ifdef PC_BREAKPOINT_EN
    assign bp_hit = bp_hit_q;
`else
    // Without the breakpoint feature the pulse register is never set.
    logic unused_bp;
    assign unused_bp = bp_hit_q;
`endif

endmodule
